// File: rtl/dffrsnq_bank_init_ctrl.sv
// Round-robin init sequencer for banks of dffrsnq flops: one bank at a time gets a clean RN/SETN pulse with its clock held off.
// Optional preset support is enabled with `define DFFRSNQ_INIT_CTRL_PRESET_EN; otherwise every request is a clear.
module dffrsnq_bank_init_ctrl #(
   parameter int NBANK     = 4,
   parameter int PULSE_CYC = 2,
   parameter int GAP_CYC   = 1
) (
   input  logic             CLK,
   input  logic             RN,
   input  logic [NBANK-1:0] req,
   input  logic [NBANK-1:0] req_set,
   output logic [NBANK-1:0] ack,
   output logic [NBANK-1:0] bank_rn,
   output logic [NBANK-1:0] bank_setn,
   output logic [NBANK-1:0] bank_clken,
   output logic             busy
);

   localparam int CMAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
   localparam int CW   = $clog2(CMAX + 1);
   localparam int PW   = $clog2(NBANK);
   localparam bit HAS_GAP = (GAP_CYC > 0);
   localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_CYC - 1);
   localparam logic [CW-1:0] GAP_LOAD   = CW'(HAS_GAP ? GAP_CYC - 1 : 0);
   localparam logic [PW-1:0] PTR_INIT   = PW'(NBANK - 1);
   localparam logic [NBANK-1:0] ONE_HOT0 = {{(NBANK-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE, ASSERT, RECOVER, DONE} stateT;

   stateT            r_state;
   logic             r_sync1;
   logic             r_rstS;
   logic [PW-1:0]    r_ptr;
   logic [PW-1:0]    r_bankIdx;
   logic [CW-1:0]    r_cnt;
   logic [NBANK-1:0] r_ack;
   logic [NBANK-1:0] r_bankRn;
   logic [NBANK-1:0] r_bankSetn;
   logic [NBANK-1:0] r_clken;
   logic             r_busy;

   logic [PW-1:0]    w_grantIdx;
   logic             w_grantVld;
   logic             w_grantSet;
   logic [PW:0]      w_sum;
   logic [PW-1:0]    w_idx;
   logic [NBANK-1:0] w_grantOh;
   logic [NBANK-1:0] w_bankOh;

   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         r_sync1 <= 1'b0;
         r_rstS  <= 1'b0;
      end else begin
         r_sync1 <= 1'b1;
         r_rstS  <= r_sync1;
      end
   end

   // Search upward from the bank after the last grant, wrapping, so the last winner has lowest priority.
   always_comb begin
      w_grantIdx = '0;
      w_grantVld = 1'b0;
      w_sum      = '0;
      w_idx      = '0;
      for (int k = 1; k <= NBANK; k++) begin
         w_sum = {1'b0, r_ptr} + (PW+1)'(k);
         if (w_sum >= (PW+1)'(NBANK)) begin
            w_sum = w_sum - (PW+1)'(NBANK);
         end
         w_idx = w_sum[PW-1:0];
         if (!w_grantVld && req[w_idx]) begin
            w_grantVld = 1'b1;
            w_grantIdx = w_idx;
         end
      end
   end

`ifdef DFFRSNQ_INIT_CTRL_PRESET_EN
   assign w_grantSet = req_set[w_grantIdx];
`else
   logic w_unusedSet;
   assign w_unusedSet = ^req_set;
   assign w_grantSet  = 1'b0;
`endif

   assign w_grantOh = ONE_HOT0 << w_grantIdx;
   assign w_bankOh  = ONE_HOT0 << r_bankIdx;

   // While the synchroniser drains, bank_rn and busy release one edge ahead of the FSM so the banks leave clear as soon as rst_s rises.
   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         r_state    <= IDLE;
         r_ptr      <= PTR_INIT;
         r_bankIdx  <= '0;
         r_cnt      <= '0;
         r_ack      <= '0;
         r_bankRn   <= '0;
         r_bankSetn <= '1;
         r_clken    <= '0;
         r_busy     <= 1'b1;
      end else if (!r_rstS) begin
         r_state    <= IDLE;
         r_ptr      <= PTR_INIT;
         r_bankIdx  <= '0;
         r_cnt      <= '0;
         r_ack      <= '0;
         r_bankRn   <= {NBANK{r_sync1}};
         r_bankSetn <= '1;
         r_clken    <= '0;
         r_busy     <= ~r_sync1;
      end else begin
         r_ack <= '0;
         case (r_state)
            IDLE: begin
               r_bankRn   <= '1;
               r_bankSetn <= '1;
               if (w_grantVld) begin
                  r_state   <= ASSERT;
                  r_bankIdx <= w_grantIdx;
                  r_ptr     <= w_grantIdx;
                  r_cnt     <= PULSE_LOAD;
                  r_busy    <= 1'b1;
                  r_clken   <= ~w_grantOh;
                  if (w_grantSet) begin
                     r_bankSetn <= ~w_grantOh;
                  end else begin
                     r_bankRn <= ~w_grantOh;
                  end
               end else begin
                  r_busy  <= 1'b0;
                  r_clken <= '1;
               end
            end
            ASSERT: begin
               if (r_cnt == '0) begin
                  r_bankRn   <= '1;
                  r_bankSetn <= '1;
                  if (HAS_GAP) begin
                     r_state <= RECOVER;
                     r_cnt   <= GAP_LOAD;
                  end else begin
                     r_state <= DONE;
                     r_ack   <= w_bankOh;
                     r_clken <= '1;
                  end
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            RECOVER: begin
               if (r_cnt == '0) begin
                  r_state <= DONE;
                  r_ack   <= w_bankOh;
                  r_clken <= '1;
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            DONE: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign ack        = r_ack;
   assign bank_rn    = r_bankRn;
   assign bank_setn  = r_bankSetn;
   assign bank_clken = r_clken;
   assign busy       = r_busy;

endmodule

// File: tb/tb_dffrsnq_bank_init_ctrl.sv
// Bench for dffrsnq_bank_init_ctrl: a default instance and a PULSE_CYC=1/GAP_CYC=0 instance checked every cycle against a timestamp model.
module tb_dffrsnq_bank_init_ctrl;

   localparam int NB = 4;
`ifdef DFFRSNQ_INIT_CTRL_PRESET_EN
   localparam bit PRESET = 1'b1;
`else
   localparam bit PRESET = 1'b0;
`endif

   logic clk;
   logic rn;
   logic [NB-1:0] reqV [2];
   logic [NB-1:0] setV [2];

   logic [NB-1:0] ackA, rnA, setnA, clkenA;
   logic          busyA;
   logic [NB-1:0] ackB, rnB, setnB, clkenB;
   logic          busyB;

   wire [4*NB:0] obsA = {ackA, rnA, setnA, clkenA, busyA};
   wire [4*NB:0] obsB = {ackB, rnB, setnB, clkenB, busyB};

   int vectors;
   int errs;

   int mEdges;
   bit mAct [2];
   int mBank [2];
   bit mSet [2];
   int mT [2];
   int mPtr [2];

   dffrsnq_bank_init_ctrl #(.NBANK(NB), .PULSE_CYC(2), .GAP_CYC(1)) dutA (
      .CLK(clk), .RN(rn), .req(reqV[0]), .req_set(setV[0]),
      .ack(ackA), .bank_rn(rnA), .bank_setn(setnA), .bank_clken(clkenA), .busy(busyA)
   );

   dffrsnq_bank_init_ctrl #(.NBANK(NB), .PULSE_CYC(1), .GAP_CYC(0)) dutB (
      .CLK(clk), .RN(rn), .req(reqV[1]), .req_set(setV[1]),
      .ack(ackB), .bank_rn(rnB), .bank_setn(setnB), .bank_clken(clkenB), .busy(busyB)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int pOf(int i);
      return (i == 0) ? 2 : 1;
   endfunction

   function automatic int gOf(int i);
      return (i == 0) ? 1 : 0;
   endfunction

   task automatic modelReset();
      mEdges = 0;
      for (int i = 0; i < 2; i++) begin
         mAct[i] = 1'b0;
         mT[i]   = 0;
         mPtr[i] = NB - 1;
      end
   endtask

   // One rising edge of the reference: edges since release, then a grant timestamp per instance.
   task automatic modelEdge();
      if (rn) begin
         if (mEdges < 3) mEdges++;
         if (mEdges >= 3) begin
            for (int i = 0; i < 2; i++) begin
               if (mAct[i]) begin
                  mT[i]++;
                  if (mT[i] > pOf(i) + gOf(i)) mAct[i] = 1'b0;
               end else if (reqV[i] != '0) begin
                  for (int k = 1; k <= NB; k++) begin
                     int idx = (mPtr[i] + k) % NB;
                     if (reqV[i][idx]) begin
                        mAct[i]  = 1'b1;
                        mT[i]    = 0;
                        mBank[i] = idx;
                        mSet[i]  = PRESET & setV[i][idx];
                        mPtr[i]  = idx;
                        break;
                     end
                  end
               end
            end
         end
      end
   endtask

   function automatic logic [4*NB:0] expOf(int i);
      logic [NB-1:0] a, r, s, c;
      logic b;
      a = '0; r = '1; s = '1; c = '1; b = 1'b0;
      if (!rn || mEdges < 2) begin
         r = '0; c = '0; b = 1'b1;
      end else if (mEdges == 2) begin
         c = '0;
      end else if (mAct[i]) begin
         b = 1'b1;
         if (mT[i] < pOf(i)) begin
            if (mSet[i]) s[mBank[i]] = 1'b0;
            else         r[mBank[i]] = 1'b0;
         end
         if (mT[i] < pOf(i) + gOf(i))  c[mBank[i]] = 1'b0;
         if (mT[i] == pOf(i) + gOf(i)) a[mBank[i]] = 1'b1;
      end
      return {a, r, s, c, b};
   endfunction

   function automatic bit modelAck(int i, int b);
      return mAct[i] && (mT[i] == pOf(i) + gOf(i)) && (mBank[i] == b);
   endfunction

   task automatic advance();
      @(posedge clk);
      modelEdge();
      #1;
   endtask

   task automatic dropOnAck();
      for (int i = 0; i < 2; i++)
         for (int b = 0; b < NB; b++)
            if (modelAck(i, b)) reqV[i][b] = 1'b0;
   endtask

   task automatic test_reset();
      rn = 1'b0;
      modelReset();
      #1;
      vectors++;
      if (obsA !== expOf(0)) begin errs++; $display("[TB] FAIL reset_async: got %h expected %h", obsA, expOf(0)); end
      vectors++;
      if ({rnA, setnA, clkenA, ackA, busyA} !== {4'h0, 4'hF, 4'h0, 4'h0, 1'b1}) begin
         errs++; $display("[TB] FAIL reset_values: got %h expected %h", {rnA, setnA, clkenA, ackA, busyA}, {4'h0, 4'hF, 4'h0, 4'h0, 1'b1});
      end
      for (int c = 0; c < 2; c++) begin
         advance();
         vectors++;
         if (obsA !== expOf(0)) begin errs++; $display("[TB] FAIL reset_hold c=%0d: got %h expected %h", c, obsA, expOf(0)); end
      end
      rn = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         advance();
         vectors++;
         if (obsA !== expOf(0)) begin errs++; $display("[TB] FAIL reset_release_a e=%0d: got %h expected %h", c, obsA, expOf(0)); end
         vectors++;
         if (obsB !== expOf(1)) begin errs++; $display("[TB] FAIL reset_release_b e=%0d: got %h expected %h", c, obsB, expOf(1)); end
         if (c == 2) begin
            vectors++;
            if ({rnA, clkenA, busyA} !== {4'hF, 4'h0, 1'b0}) begin
               errs++; $display("[TB] FAIL release_edge2: got %h expected %h", {rnA, clkenA, busyA}, {4'hF, 4'h0, 1'b0});
            end
         end
         if (c == 3) begin
            vectors++;
            if ({setnA, clkenA, busyA} !== {4'hF, 4'hF, 1'b0}) begin
               errs++; $display("[TB] FAIL release_edge3: got %h expected %h", {setnA, clkenA, busyA}, {4'hF, 4'hF, 1'b0});
            end
         end
      end
   endtask

   task automatic test_clear();
      int rnLow, ceLow, ackCyc;
      rnLow = 0; ceLow = 0; ackCyc = -1;
      reqV[0] = 4'b0010;
      setV[0] = 4'b0000;
      for (int c = 0; c < 8; c++) begin
         advance();
         vectors++;
         if (obsA !== expOf(0)) begin errs++; $display("[TB] FAIL clear c=%0d: got %h expected %h", c, obsA, expOf(0)); end
         if (rnA[1] === 1'b0) rnLow++;
         if (clkenA[1] === 1'b0) ceLow++;
         if (ackA === 4'b0010 && ackCyc < 0) ackCyc = c;
         dropOnAck();
      end
      vectors++;
      if (rnLow != 2) begin errs++; $display("[TB] FAIL clear_pulse_width: got %0d expected 2", rnLow); end
      vectors++;
      if (ceLow != 3) begin errs++; $display("[TB] FAIL clear_clken_width: got %0d expected 3", ceLow); end
      vectors++;
      if (ackCyc != 3) begin errs++; $display("[TB] FAIL clear_ack_latency: got %0d expected 3", ackCyc); end
   endtask

   task automatic test_preset();
      int snLow, rnLow;
      snLow = 0; rnLow = 0;
      reqV[0] = 4'b1000;
      setV[0] = 4'b1000;
      for (int c = 0; c < 8; c++) begin
         advance();
         vectors++;
         if (obsA !== expOf(0)) begin errs++; $display("[TB] FAIL preset c=%0d: got %h expected %h", c, obsA, expOf(0)); end
         if (setnA[3] === 1'b0) snLow++;
         if (rnA[3] === 1'b0) rnLow++;
         if (c == 0) setV[0] = 4'b0000;
         dropOnAck();
      end
      vectors++;
      if (snLow != (PRESET ? 2 : 0)) begin errs++; $display("[TB] FAIL preset_setn_width: got %0d expected %0d", snLow, PRESET ? 2 : 0); end
      vectors++;
      if (rnLow != (PRESET ? 0 : 2)) begin errs++; $display("[TB] FAIL preset_rn_width: got %0d expected %0d", rnLow, PRESET ? 0 : 2); end
   endtask

   task automatic test_round_robin();
      int expOrd [5];
      int nAck, cyc, got;
      bit reraised;
      expOrd = '{0, 1, 2, 3, 0};
      nAck = 0; cyc = 0; reraised = 1'b0;
      rn = 1'b0;
      modelReset();
      #1;
      advance();
      vectors++;
      if (obsA !== expOf(0)) begin errs++; $display("[TB] FAIL rr_reset: got %h expected %h", obsA, expOf(0)); end
      rn = 1'b1;
      for (int c = 0; c < 3; c++) advance();
      reqV[0] = 4'b1111;
      setV[0] = 4'b0000;
      while (nAck < 5 && cyc < 80) begin
         advance();
         cyc++;
         vectors++;
         if (obsA !== expOf(0)) begin errs++; $display("[TB] FAIL rr_cycle c=%0d: got %h expected %h", cyc, obsA, expOf(0)); end
         if (ackA !== 4'b0000) begin
            got = -1;
            for (int b = 0; b < NB; b++) if (ackA[b] === 1'b1) got = b;
            vectors++;
            if (got != expOrd[nAck]) begin errs++; $display("[TB] FAIL rr_order n=%0d: got %0d expected %0d", nAck, got, expOrd[nAck]); end
            nAck++;
         end
         dropOnAck();
         if (mAct[0] && mBank[0] == 2 && !reraised) begin
            reqV[0][0] = 1'b1;
            reraised   = 1'b1;
         end
      end
      vectors++;
      if (nAck != 5) begin errs++; $display("[TB] FAIL rr_timeout: got %0d acks expected 5", nAck); end
      reqV[0] = 4'b0000;
      for (int c = 0; c < 3; c++) advance();
   endtask

   task automatic test_abort();
      int firstAck;
      firstAck = -1;
      reqV[0] = 4'b0100;
      setV[0] = 4'b0000;
      for (int c = 0; c < 2; c++) begin
         advance();
         vectors++;
         if (obsA !== expOf(0)) begin errs++; $display("[TB] FAIL abort_pre c=%0d: got %h expected %h", c, obsA, expOf(0)); end
      end
      rn = 1'b0;
      modelReset();
      #1;
      vectors++;
      if ({rnA, setnA, clkenA, ackA} !== {4'h0, 4'hF, 4'h0, 4'h0}) begin
         errs++; $display("[TB] FAIL abort_immediate: got %h expected %h", {rnA, setnA, clkenA, ackA}, {4'h0, 4'hF, 4'h0, 4'h0});
      end
      for (int c = 0; c < 2; c++) begin
         advance();
         vectors++;
         if (obsA !== expOf(0)) begin errs++; $display("[TB] FAIL abort_hold c=%0d: got %h expected %h", c, obsA, expOf(0)); end
      end
      reqV[0] = 4'b1100;
      rn = 1'b1;
      for (int c = 0; c < 16; c++) begin
         advance();
         vectors++;
         if (obsA !== expOf(0)) begin errs++; $display("[TB] FAIL abort_after c=%0d: got %h expected %h", c, obsA, expOf(0)); end
         if (firstAck < 0 && ackA !== 4'b0000) begin
            for (int b = 0; b < NB; b++) if (ackA[b] === 1'b1) firstAck = b;
         end
         dropOnAck();
      end
      vectors++;
      if (firstAck != 2) begin errs++; $display("[TB] FAIL abort_ptr_restart: got %0d expected 2", firstAck); end
   endtask

   task automatic test_fast_path();
      int ceLow, ackCyc;
      ceLow = 0; ackCyc = -1;
      reqV[1] = 4'b0010;
      setV[1] = 4'b0000;
      for (int c = 0; c < 5; c++) begin
         advance();
         vectors++;
         if (obsB !== expOf(1)) begin errs++; $display("[TB] FAIL fast c=%0d: got %h expected %h", c, obsB, expOf(1)); end
         if (clkenB[1] === 1'b0) ceLow++;
         if (ackB === 4'b0010 && ackCyc < 0) ackCyc = c;
         dropOnAck();
      end
      vectors++;
      if (ackCyc != 1) begin errs++; $display("[TB] FAIL fast_ack_latency: got %0d expected 1", ackCyc); end
      vectors++;
      if (ceLow != 1) begin errs++; $display("[TB] FAIL fast_clken_width: got %0d expected 1", ceLow); end
   endtask

   task automatic test_random();
      for (int c = 0; c < 500; c++) begin
         advance();
         vectors++;
         if (obsA !== expOf(0)) begin errs++; $display("[TB] FAIL random_a c=%0d: got %h expected %h", c, obsA, expOf(0)); end
         vectors++;
         if (obsB !== expOf(1)) begin errs++; $display("[TB] FAIL random_b c=%0d: got %h expected %h", c, obsB, expOf(1)); end
         if (!rn) begin
            rn = 1'b1;
         end else if ($urandom_range(0, 149) == 0) begin
            rn = 1'b0;
            modelReset();
            #1;
            vectors++;
            if (obsA !== expOf(0)) begin errs++; $display("[TB] FAIL random_abort c=%0d: got %h expected %h", c, obsA, expOf(0)); end
         end
         for (int i = 0; i < 2; i++) begin
            for (int b = 0; b < NB; b++) begin
               if (modelAck(i, b)) begin
                  reqV[i][b] = ($urandom_range(0, 3) == 0);
               end else if (!reqV[i][b] && $urandom_range(0, 3) == 0) begin
                  reqV[i][b] = 1'b1;
                  setV[i][b] = 1'($urandom);
               end else if ($urandom_range(0, 7) == 0) begin
                  setV[i][b] = 1'($urandom);
               end
            end
         end
      end
   endtask

   initial begin
      vectors = 0;
      errs    = 0;
      rn      = 1'b1;
      reqV[0] = '0; reqV[1] = '0;
      setV[0] = '0; setV[1] = '0;
      modelReset();
      #3;
      test_reset();
      test_clear();
      test_preset();
      test_round_robin();
      test_abort();
      test_fast_path();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
